// File: rtl/asi_pkg.sv
// Shared types and helpers for the async FIFO read-side unpacker.
// Slice selection is done on a fixed wide word so one function serves every DW.
package asi_pkg;

    localparam int MAXW = 1024;

    typedef enum logic {
        S_EMPTY,
        S_UNPACK
    } state_t;

    function automatic int ratio(int dw, int ow);
        return dw / ow;
    endfunction

    function automatic int idx_w(int dw, int ow);
        return (dw / ow > 1) ? $clog2(dw / ow) : 1;
    endfunction

    // Returns the selected slice in the low bits; caller truncates to OW.
    function automatic logic [MAXW-1:0] slice_sel(
        logic [MAXW-1:0] w,
        int              k,
        int              ow,
        int              r,
        bit              msb
    );
        int s;
        s = msb ? (r - 1 - k) : k;
        return w >> (s * ow);
    endfunction

endpackage

// File: rtl/afifo_rd_unpack_if.sv
// FIFO show-ahead read port plus the narrow beat stream.
// master = the unpacker, slave = FIFO/consumer side.
interface afifo_rd_unpack_if #(
    parameter int DW = 128,
    parameter int OW = 32
);
    logic          rempty;
    logic          re;
    logic [DW-1:0] q;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;

    modport master (
        input  rempty, q, m_ready,
        output re, m_valid, m_data, m_last
    );

    modport slave (
        output rempty, q, m_ready,
        input  re, m_valid, m_data, m_last
    );
endinterface

// File: rtl/afifo_rd_unpack.sv
// Pops wide words from a show-ahead FIFO and serialises them into
// registered OW-bit beats, one per cycle across word boundaries.
module afifo_rd_unpack
    import asi_pkg::*;
#(
    parameter int DW        = 128,
    parameter int OW        = 32,
    parameter int MSB_FIRST = 0
)(
    input  logic rclk,
    input  logic rreset_n,
    input  logic clr,
    output logic busy,
    afifo_rd_unpack_if.master bus
);

    localparam int R  = ratio(DW, OW);
    localparam int IW = idx_w(DW, OW);

    state_t        r_state;
    logic [DW-1:0] r_hold;
    logic [IW-1:0] r_idx;
    logic [OW-1:0] r_m_data;
    logic          r_m_last;
    logic          r_m_valid;

    state_t        w_state_nxt;
    logic [DW-1:0] w_hold_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [OW-1:0] w_m_data_nxt;
    logic          w_m_last_nxt;
    logic          w_m_valid_nxt;

    logic          w_hold_vld;
    logic          w_out_adv;
    logic          w_last;
    logic          w_hold_free;
    logic          w_re;
    logic [OW-1:0] w_slice;

    assign w_hold_vld  = (r_state == S_UNPACK);
    assign w_out_adv   = !r_m_valid || bus.m_ready;
    assign w_last      = w_hold_vld && (r_idx == IW'(R - 1));
    assign w_hold_free = !w_hold_vld || (w_out_adv && w_last);
    assign w_re        = !bus.rempty && w_hold_free && !clr;
    assign w_slice     = OW'(slice_sel(MAXW'(r_hold), int'(r_idx), OW, R,
                                       MSB_FIRST != 0));

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_idx_nxt     = r_idx;
        w_m_data_nxt  = r_m_data;
        w_m_last_nxt  = r_m_last;
        w_m_valid_nxt = r_m_valid;
        if (clr) begin
            w_state_nxt   = S_EMPTY;
            w_idx_nxt     = '0;
            w_m_valid_nxt = 1'b0;
        end else begin
            if (w_out_adv && w_hold_vld) begin
                w_m_data_nxt  = w_slice;
                w_m_last_nxt  = w_last;
                w_m_valid_nxt = 1'b1;
                w_idx_nxt     = r_idx + 1'b1;
                if (w_last) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_EMPTY;
                end
            end else if (w_out_adv) begin
                w_m_valid_nxt = 1'b0;
            end
            // A reload on the last slice keeps the stream bubble-free.
            if (w_re) begin
                w_hold_nxt  = bus.q;
                w_state_nxt = S_UNPACK;
                w_idx_nxt   = '0;
            end
        end
    end

    always_ff @(posedge rclk or negedge rreset_n) begin
        if (!rreset_n) begin
            r_state   <= S_EMPTY;
            r_hold    <= '0;
            r_idx     <= '0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_idx     <= w_idx_nxt;
            r_m_data  <= w_m_data_nxt;
            r_m_last  <= w_m_last_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    assign bus.re      = w_re;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_last  = r_m_last;
    assign busy        = w_hold_vld || r_m_valid;

endmodule

// File: tb/tb_afifo_rd_unpack.sv
// Directed bench for afifo_rd_unpack: DW=32, OW=8, one LSB-first and
// one MSB-first instance, each fed by a queue-based show-ahead FIFO model.
module tb_afifo_rd_unpack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr0 = 1'b0;
    logic clr1 = 1'b0;
    logic busy0;
    logic busy1;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] fq0[$];
    logic [31:0] fq1[$];

    always #5 clk = ~clk;

    afifo_rd_unpack_if #(.DW(32), .OW(8)) if0();
    afifo_rd_unpack_if #(.DW(32), .OW(8)) if1();

    afifo_rd_unpack #(.DW(32), .OW(8), .MSB_FIRST(0)) u_lsb (
        .rclk     (clk),
        .rreset_n (rst_n),
        .clr      (clr0),
        .busy     (busy0),
        .bus      (if0.master)
    );

    afifo_rd_unpack #(.DW(32), .OW(8), .MSB_FIRST(1)) u_msb (
        .rclk     (clk),
        .rreset_n (rst_n),
        .clr      (clr1),
        .busy     (busy1),
        .bus      (if1.master)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        if0.rempty = (fq0.size() == 0);
        if0.q      = (fq0.size() != 0) ? fq0[0] : 32'h0;
        if1.rempty = (fq1.size() == 0);
        if1.q      = (fq1.size() != 0) ? fq1[0] : 32'h0;
    endtask

    // re is sampled mid-cycle; the pop lands just after the edge.
    task automatic tick();
        logic p0;
        logic p1;
        @(negedge clk);
        p0 = if0.re;
        p1 = if1.re;
        @(posedge clk);
        #1;
        if (p0 && fq0.size() != 0) void'(fq0.pop_front());
        if (p1 && fq1.size() != 0) void'(fq1.pop_front());
        refresh();
    endtask

    task automatic beat0(string tag, logic [7:0] d, logic l);
        check({tag, "_v"}, {31'h0, if0.m_valid}, 32'h1);
        check({tag, "_d"}, {24'h0, if0.m_data}, {24'h0, d});
        check({tag, "_l"}, {31'h0, if0.m_last}, {31'h0, l});
    endtask

    task automatic drain0();
        int n;
        n = 0;
        if0.m_ready = 1'b1;
        while ((busy0 || fq0.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check("drain_timeout", {31'h0, busy0}, 32'h0);
    endtask

    logic [7:0] exp2 [8];
    logic [7:0] exp4 [4];

    initial begin
        exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        exp4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        if0.m_ready = 1'b1;
        if1.m_ready = 1'b1;
        refresh();
        #3;
        check("rst_valid", {31'h0, if0.m_valid}, 32'h0);
        check("rst_data", {24'h0, if0.m_data}, 32'h0);
        check("rst_last", {31'h0, if0.m_last}, 32'h0);
        check("rst_busy", {31'h0, busy0}, 32'h0);
        check("rst_re", {31'h0, if0.re}, 32'h0);
        #20;
        rst_n = 1'b1;
        tick();

        // single word, latency and order
        fq0.push_back(32'h44332211);
        refresh();
        #1;
        check("t1_re", {31'h0, if0.re}, 32'h1);
        tick();
        check("t1_lat", {31'h0, if0.m_valid}, 32'h0);
        check("t1_busy", {31'h0, busy0}, 32'h1);
        tick(); beat0("t1_b0", 8'h11, 1'b0);
        tick(); beat0("t1_b1", 8'h22, 1'b0);
        tick(); beat0("t1_b2", 8'h33, 1'b0);
        tick(); beat0("t1_b3", 8'h44, 1'b1);
        tick();
        check("t1_idle", {31'h0, if0.m_valid}, 32'h0);
        check("t1_ibusy", {31'h0, busy0}, 32'h0);

        // two words back to back, no bubble
        fq0.push_back(32'h44332211);
        fq0.push_back(32'h88776655);
        refresh();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            beat0($sformatf("t2_b%0d", i), exp2[i], (i % 4) == 3);
            if (i == 1) check("t2_re_lo", {31'h0, if0.re}, 32'h0);
            if (i == 2) check("t2_re_hi", {31'h0, if0.re}, 32'h1);
        end
        tick();
        check("t2_idle", {31'h0, if0.m_valid}, 32'h0);

        // backpressure on beat 0x22
        fq0.push_back(32'h44332211);
        refresh();
        tick(); tick(); tick();
        beat0("t3_b1", 8'h22, 1'b0);
        if0.m_ready = 1'b0;
        fq0.push_back(32'hDDCCBBAA);
        refresh();
        for (int i = 0; i < 5; i++) begin
            tick();
            beat0($sformatf("t3_hold%0d", i), 8'h22, 1'b0);
            check($sformatf("t3_fq%0d", i), fq0.size(), 32'd1);
        end
        if0.m_ready = 1'b1;
        tick(); beat0("t3_b2", 8'h33, 1'b0);
        tick(); beat0("t3_b3", 8'h44, 1'b1);
        tick(); beat0("t3_n0", 8'hAA, 1'b0);
        drain0();

        // MSB-first instance
        fq1.push_back(32'hAABBCCDD);
        refresh();
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_v%0d", i), {31'h0, if1.m_valid}, 32'h1);
            check($sformatf("t4_d%0d", i), {24'h0, if1.m_data},
                  {24'h0, exp4[i]});
            check($sformatf("t4_l%0d", i), {31'h0, if1.m_last},
                  {31'h0, i == 3});
            tick();
        end
        check("t4_idle", {31'h0, if1.m_valid}, 32'h0);

        // flush while beat 0x22 pending, 2 words left in FIFO
        fq0.push_back(32'h44332211);
        fq0.push_back(32'h88776655);
        fq0.push_back(32'hCAFEF00D);
        refresh();
        tick(); tick(); tick();
        beat0("t5_b1", 8'h22, 1'b0);
        check("t5_fq", fq0.size(), 32'd2);
        clr0 = 1'b1;
        #1;
        check("t5_re", {31'h0, if0.re}, 32'h0);
        tick();
        clr0 = 1'b0;
        check("t5_valid", {31'h0, if0.m_valid}, 32'h0);
        check("t5_busy", {31'h0, busy0}, 32'h0);
        check("t5_nopop", fq0.size(), 32'd2);
        tick();
        check("t5_gap", {31'h0, if0.m_valid}, 32'h0);
        tick(); beat0("t5_n0", 8'h55, 1'b0);
        drain0();

        // async reset mid-word
        fq0.push_back(32'h44332211);
        refresh();
        tick(); tick(); tick();
        beat0("t6_b1", 8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'h0, if0.m_valid}, 32'h0);
        check("t6_data", {24'h0, if0.m_data}, 32'h0);
        check("t6_last", {31'h0, if0.m_last}, 32'h0);
        check("t6_busy", {31'h0, busy0}, 32'h0);
        rst_n = 1'b1;
        fq0.push_back(32'h04030201);
        refresh();
        tick(); tick();
        beat0("t6_n0", 8'h01, 1'b0);
        tick(); beat0("t6_n1", 8'h02, 1'b0);
        drain0();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
